fft_result_unloader: RTL
========================

// Module: fft_result_unloader
// PURPOSE
//  Read-side sequencer for the FFT working buffer: after the final butterfly stage, walks all N points
//  through the buffer read port (rd_en/rd_addr -> rd_data) and streams them to the host on a
//  valid/ready interface. Applies bit-reversed address order so samples leave in natural frequency order.
//  Counterpart of the host write path that loads samples via write_enable/write_address/data_in.
// PARAMETERS
//  ADDR_W    4   buffer address width; N_POINTS = 2**ADDR_W
//  DATA_W    32  word width, {real[31:16], imag[15:0]}, passed through unmodified
//  BITREV    1   1: rd_addr = bit-reverse(index); 0: rd_addr = index
//  READ_LAT  1   clocks from rd_en to valid rd_data (buffer read latency, >=1)
// PORTS
//  clk       in   1       clock, all logic on rising edge
//  rst       in   1       synchronous reset, active-high
//  start     in   1       begin unload; sampled only in IDLE
//  busy      out  1       high from cycle after accepted start until done pulse
//  done      out  1       one-cycle pulse after last beat accepted
//  rd_en     out  1       buffer read strobe
//  rd_addr   out  ADDR_W  buffer read address
//  rd_data   in   DATA_W  buffer read data, valid READ_LAT clocks after rd_en
//  m_valid   out  1       output word valid
//  m_ready   in   1       host accepts word when m_valid & m_ready
//  m_data    out  DATA_W  output word
//  m_index   out  ADDR_W  natural-order index of m_data (0..N_POINTS-1)
//  m_last    out  1       high with index N_POINTS-1
// BEHAVIOUR
//  Reset (rst=1 at edge): state IDLE; busy, done, rd_en, m_valid, m_last = 0; rd_addr, m_data, m_index = 0;
//   issue counter, in-flight counter, output FIFO cleared. Reset mid-unload aborts; no done pulse.
//  FSM: IDLE -(start)-> READ -(all N reads issued)-> DRAIN -(last beat accepted)-> DONE -> IDLE.
//   DONE lasts exactly one cycle and drives done=1, busy=0. start outside IDLE ignored, no queuing.
//  Issue: in READ, rd_en=1 when (fifo_count + inflight - pop) < DEPTH, DEPTH = READ_LAT+1, pop = m_valid&m_ready.
//   Each issue increments index (0..N_POINTS-1); rd_addr = BITREV ? bitrev(index) : index. rd_en=0 otherwise.
//  Capture: a shift register of depth READ_LAT tags each read with its index; data and index written
//   to the output FIFO at the edge where rd_data is valid. FIFO never overflows by construction
//   (assertion: push while full is an error).
//  Output: m_valid = FIFO non-empty; m_data/m_index/m_last from FIFO head; registered outputs,
//   stable while m_valid & !m_ready. Simultaneous push and pop in one cycle permitted at any count.
//  Latency (READ_LAT=1): start sampled at edge 0; rd_en high cycle 1; rd_data cycle 2; m_valid cycle 3.
//  Throughput: 1 word/clock with m_ready held high; last beat at cycle N_POINTS+2, done at N_POINTS+3.
//  Backpressure: m_ready=0 halts issue once FIFO+in-flight reaches DEPTH; no word dropped or duplicated.
//  Wrap: index counter stops at N_POINTS-1; does not wrap into a second pass.
// TESTING
//  1 Buffer word k = {k,~k}, BITREV=1, m_ready=1, start -> m_data order addr 0,8,4,12,2,10,...,15;
//    m_index 0..15; m_last on 16th; m_valid first at cycle 3; done at cycle 19, single pulse.
//  2 Same, BITREV=0 -> rd_addr sequence 0..15, m_data = {k,~k} in natural order.
//  3 m_ready toggles 1,0,0,1 pattern -> exactly 16 beats, no loss/duplicate, m_data held stable
//    when stalled; rd_en never issued while FIFO+in-flight = DEPTH.
//  4 start pulsed again at cycles 5 and 10 during unload -> ignored; one done; busy stays high.
//  5 rst asserted after 6th beat -> next cycle all outputs 0, state IDLE, no done; fresh start
//    replays from index 0.
//  6 READ_LAT=2 build, m_ready=1 -> 1 word/clock sustained, first m_valid at cycle 4, same order as test 1.

Source files
------------

// File: rtl/fft_result_unloader.sv
// Read-side sequencer for the FFT working buffer: walks all N points out of the buffer
// read port (optionally in bit-reversed address order) and streams them on valid/ready.
module fft_result_unloader #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 32,
    parameter int BITREV   = 1,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_index,
    output logic              m_last,
    output logic [1:0]        dbg_state
);
    localparam int N_POINTS = 1 << ADDR_W;
    localparam int DEPTH    = READ_LAT + 1;
    // The read strobe is registered, so one extra slot absorbs the read already on the bus
    // when the issue decision is made.
    localparam int SLOTS    = DEPTH + 1;
    localparam int PW       = $clog2(SLOTS);
    localparam int CW       = $clog2(SLOTS + 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t                     state;
    logic [ADDR_W-1:0]          issue_idx;
    logic [ADDR_W-1:0]          rd_idx_q;
    logic [READ_LAT-1:0]        sr_vld;
    logic [ADDR_W-1:0]          sr_idx [READ_LAT];
    logic [ADDR_W+DATA_W-1:0]   fifo_mem [SLOTS];
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              fifo_count;
    logic                       push, pop, issue;
    logic [ADDR_W-1:0]          push_idx;
    int                         sr_cnt;
    int                         occ;

    function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] v);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) r[i] = v[ADDR_W-1-i];
        return r;
    endfunction

    // Host handshake: a word transfers on every rising edge where m_valid && m_ready;
    // m_valid never drops and m_data/m_index/m_last never change until that transfer.
    assign m_valid   = (fifo_count != '0);
    assign m_data    = fifo_mem[rd_ptr][DATA_W-1:0];
    assign m_index   = fifo_mem[rd_ptr][ADDR_W+DATA_W-1:DATA_W];
    assign m_last    = m_valid && (m_index == ADDR_W'(N_POINTS - 1));
    assign dbg_state = state;

    assign pop      = m_valid && m_ready;
    assign push     = sr_vld[READ_LAT-1];
    assign push_idx = sr_idx[READ_LAT-1];

    always_comb begin
        sr_cnt = 0;
        for (int i = 0; i < READ_LAT; i++) sr_cnt = sr_cnt + int'(sr_vld[i]);
        occ   = int'(fifo_count) + sr_cnt - int'(pop);
        issue = (state == S_READ) && (occ < DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            rd_idx_q   <= '0;
            issue_idx  <= '0;
            sr_vld     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < READ_LAT; i++) sr_idx[i] <= '0;
            for (int i = 0; i < SLOTS; i++) fifo_mem[i] <= '0;
        end else begin
            rd_en <= issue;
            if (issue) begin
                rd_addr   <= (BITREV != 0) ? bit_rev(issue_idx) : issue_idx;
                rd_idx_q  <= issue_idx;
                if (issue_idx != ADDR_W'(N_POINTS - 1)) issue_idx <= issue_idx + 1'b1;
            end

            // Tag each read with its natural index until its data arrives.
            sr_vld[0] <= rd_en;
            sr_idx[0] <= rd_idx_q;
            for (int i = 1; i < READ_LAT; i++) begin
                sr_vld[i] <= sr_vld[i-1];
                sr_idx[i] <= sr_idx[i-1];
            end

            if (push) begin
                assert (fifo_count != CW'(SLOTS)) else $error("output fifo push while full");
                fifo_mem[wr_ptr] <= {push_idx, rd_data};
                wr_ptr <= (wr_ptr == PW'(SLOTS - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= (rd_ptr == PW'(SLOTS - 1)) ? '0 : rd_ptr + 1'b1;
            fifo_count <= fifo_count + CW'(push) - CW'(pop);

            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_READ;
                        busy      <= 1'b1;
                        issue_idx <= '0;
                    end
                end
                S_READ: begin
                    if (issue && issue_idx == ADDR_W'(N_POINTS - 1)) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (pop && m_last) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
